// File: rtl/cache_subsystem.sv
// Set-associative (1- or 2-way) write-back / write-allocate cache with single-word lines,
// a valid/ready request port, a done-pulse RAM port and saturating hit/miss counters.
module cache_subsystem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_done,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_victim;
    logic                  r_reqReady;
    logic                  r_respValid;
    logic [DATA_WIDTH-1:0] r_respRdata;
    logic                  r_memRead;
    logic                  r_memWrite;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic [CNT_WIDTH-1:0]  r_hitCnt;
    logic [CNT_WIDTH-1:0]  r_missCnt;

    // Storage always holds two ways; with WAYS=1 way 1 is never selected and is trimmed away.
    logic [TAG_BITS-1:0]   r_tag  [2][SETS];
    logic [DATA_WIDTH-1:0] r_data [2][SETS];
    logic [SETS-1:0]       r_valid [2];
    logic [SETS-1:0]       r_dirty [2];
    logic [SETS-1:0]       r_lru;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic                  w_hitWay;
    logic                  w_victim;
    logic                  w_victimDirty;
    logic                  w_touch;
    logic                  w_fill;
    logic                  w_way;
    logic [DATA_WIDTH-1:0] w_fillData;
    logic                  w_fillDirty;

    assign w_index       = r_addr[INDEX_BITS-1:0];
    assign w_tag         = r_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign w_hit0        = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_hit1        = (WAYS == 2) && r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_hit         = w_hit0 | w_hit1;
    assign w_hitWay      = !w_hit0;
    assign w_victim      = ((WAYS == 1) || !r_valid[0][w_index]) ? 1'b0 :
                           (!r_valid[1][w_index] ? 1'b1 : r_lru[w_index]);
    assign w_victimDirty = r_valid[w_victim][w_index] && r_dirty[w_victim][w_index];

    // Touch updates LRU only; fill also writes tag/data/valid/dirty into the chosen way.
    always_comb begin
        w_touch     = 1'b0;
        w_fill      = 1'b0;
        w_way       = r_victim;
        w_fillData  = r_wdata;
        w_fillDirty = 1'b1;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    w_touch = 1'b1;
                    w_fill  = r_write;
                    w_way   = w_hitWay;
                end else if (!w_victimDirty && r_write) begin
                    w_touch = 1'b1;
                    w_fill  = 1'b1;
                    w_way   = w_victim;
                end
            end
            S_WRITEBACK: begin
                if (mem_done && r_write) begin
                    w_touch = 1'b1;
                    w_fill  = 1'b1;
                end
            end
            S_REFILL: begin
                if (mem_done) begin
                    w_touch     = 1'b1;
                    w_fill      = 1'b1;
                    w_fillData  = mem_rdata;
                    w_fillDirty = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
        end else begin
            if (w_touch) r_lru[w_index] <= ~w_way;
            if (w_fill) begin
                r_tag[w_way][w_index]   <= w_tag;
                r_data[w_way][w_index]  <= w_fillData;
                r_valid[w_way][w_index] <= 1'b1;
                r_dirty[w_way][w_index] <= w_fillDirty;
            end
        end
    end

    // Control FSM; every port output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_victim    <= 1'b0;
            r_reqReady  <= 1'b1;
            r_respValid <= 1'b0;
            r_respRdata <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_hitCnt    <= '0;
            r_missCnt   <= '0;
        end else begin
            r_respValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_write    <= req_write;
                        r_wdata    <= req_wdata;
                        r_reqReady <= 1'b0;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hitCnt != '1) r_hitCnt <= r_hitCnt + 1'b1;
                        if (!r_write) r_respRdata <= r_data[w_hitWay][w_index];
                        r_respValid <= 1'b1;
                        r_state     <= S_RESPOND;
                    end else begin
                        if (r_missCnt != '1) r_missCnt <= r_missCnt + 1'b1;
                        r_victim <= w_victim;
                        if (w_victimDirty) begin
                            r_memWrite <= 1'b1;
                            r_memAddr  <= {r_tag[w_victim][w_index], w_index};
                            r_memWdata <= r_data[w_victim][w_index];
                            r_state    <= S_WRITEBACK;
                        end else if (!r_write) begin
                            r_memRead <= 1'b1;
                            r_memAddr <= r_addr;
                            r_state   <= S_REFILL;
                        end else begin
                            r_respValid <= 1'b1;
                            r_state     <= S_RESPOND;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_done) begin
                        r_memWrite <= 1'b0;
                        if (r_write) begin
                            r_respValid <= 1'b1;
                            r_state     <= S_RESPOND;
                        end else begin
                            r_memRead <= 1'b1;
                            r_memAddr <= r_addr;
                            r_state   <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_done) begin
                        r_memRead   <= 1'b0;
                        r_respRdata <= mem_rdata;
                        r_respValid <= 1'b1;
                        r_state     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_reqReady <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_reqReady;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;
    assign mem_read   = r_memRead;
    assign mem_write  = r_memWrite;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;
    assign hit_count  = r_hitCnt;
    assign miss_count = r_missCnt;
endmodule
